bypass_burst_ctrl: RTL

Sequencer for bypass (equiprobable) bin decoding in the VVC arithmetic decoder. It accepts a request for a burst of N bypass bins together with the current range and value. It then pulls one bitstream bit per cycle, runs one bypass step per bit, and returns the packed bins plus the updated value. It sits between the syntax-element parser, which issues requests, and the bitstream fetch unit, which supplies the bits.

---
 rtl/bypass_pkg.sv | 15 +
 rtl/bypass_bin_step.sv | 24 ++
 rtl/bypass_burst_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bypass_pkg.sv
// Shared types and constants for the bypass-bin burst decoder.
package bypass_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } state_t;

    localparam int SCALE_SHIFT      = 7;
    localparam int RANGE_W          = 9;
    localparam int VALUE_W          = 16;
    localparam int DEFAULT_MAX_BINS = 16;

endpackage

// File: rtl/bypass_bin_step.sv
// One equiprobable (bypass) arithmetic-decoder step: shifts a bitstream bit
// into the value and compares it against the scaled range.
module bypass_bin_step
    import bypass_pkg::*;
(
    input  logic [RANGE_W-1:0] range_i,
    input  logic [VALUE_W-1:0] value_i,
    input  logic               bit_i,
    output logic               bin_o,
    output logic [VALUE_W-1:0] value_o
);

    logic [VALUE_W-1:0] scaled;
    logic [VALUE_W:0]   shifted;
    logic [VALUE_W:0]   diff;

    // The 17-bit compare keeps the carried-out MSB of the shifted value visible.
    assign scaled  = {range_i, {SCALE_SHIFT{1'b0}}};
    assign shifted = {value_i, bit_i};
    assign diff    = shifted - {1'b0, scaled};
    assign bin_o   = (shifted >= {1'b0, scaled});
    assign value_o = bin_o ? diff[VALUE_W-1:0] : shifted[VALUE_W-1:0];

endmodule

// File: rtl/bypass_burst_ctrl.sv
// Burst sequencer for bypass bins: one bitstream bit and one bin per cycle.
// Optional saturating perf counters are enabled by the BYPASS_PERF_CNT_EN macro.
module bypass_burst_ctrl
    import bypass_pkg::*;
#(
    parameter int MAX_BINS = DEFAULT_MAX_BINS,
    parameter int CNT_W    = $clog2(MAX_BINS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CNT_W-1:0]    req_num_bins,
    input  logic [RANGE_W-1:0]  req_range,
    input  logic [VALUE_W-1:0]  req_value,
    input  logic                bit_valid,
    input  logic                bit_data,
    output logic                bit_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [MAX_BINS-1:0] res_bins,
    output logic [CNT_W-1:0]    res_num_bins,
    output logic [VALUE_W-1:0]  res_value,
    output logic [31:0]         perf_bins,
    output logic [31:0]         perf_stall
);

    state_t              state_q;
    logic [RANGE_W-1:0]  range_q;
    logic [VALUE_W-1:0]  value_q;
    logic [MAX_BINS-1:0] bins_q;
    logic [CNT_W-1:0]    numBins_q;
    logic [CNT_W-1:0]    remain_q;

    logic [CNT_W-1:0]    clampedNum_d;
    logic                stepBin;
    logic [VALUE_W-1:0]  stepValue;

    assign clampedNum_d = (req_num_bins > CNT_W'(MAX_BINS)) ? CNT_W'(MAX_BINS) : req_num_bins;

    bypass_bin_step u_step (
        .range_i (range_q),
        .value_i (value_q),
        .bit_i   (bit_data),
        .bin_o   (stepBin),
        .value_o (stepValue)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            range_q   <= '0;
            value_q   <= '0;
            bins_q    <= '0;
            numBins_q <= '0;
            remain_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        range_q   <= req_range;
                        value_q   <= req_value;
                        bins_q    <= '0;
                        numBins_q <= clampedNum_d;
                        remain_q  <= clampedNum_d;
                        state_q   <= (clampedNum_d == '0) ? DONE : DECODE;
                    end
                end
                DECODE: begin
                    if (bit_valid) begin
                        value_q  <= stepValue;
                        bins_q   <= {bins_q[MAX_BINS-2:0], stepBin};
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == CNT_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // bit_ready is masked by reset so the fetch unit never loses a bit to a reset cycle.
    assign req_ready    = (state_q == IDLE);
    assign bit_ready    = (state_q == DECODE) && rst_n;
    assign res_valid    = (state_q == DONE);
    assign res_bins     = bins_q;
    assign res_num_bins = numBins_q;
    assign res_value    = value_q;

`ifdef BYPASS_PERF_CNT_EN
    logic [31:0] perfBins_q;
    logic [31:0] perfStall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perfBins_q  <= '0;
            perfStall_q <= '0;
        end else if (state_q == DECODE) begin
            if (bit_valid && (perfBins_q != 32'hFFFF_FFFF)) begin
                perfBins_q <= perfBins_q + 32'd1;
            end
            if (!bit_valid && (perfStall_q != 32'hFFFF_FFFF)) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign perf_bins  = perfBins_q;
    assign perf_stall = perfStall_q;
`else
    assign perf_bins  = '0;
    assign perf_stall = '0;
`endif

endmodule
